instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
// Upstream stage of MemoryController: holds the PC, issues instruction fetch requests on
// PCAddressBus/PCGetNewInstruction, captures InstructionBus on ValidMemoryData and hands one
// instruction at a time to decode via a valid/ready handshake. Redirects on taken branches and
// discards wrong-path fetches; re-issues a fetch if the controller never answers.
// PARAMETERS
// RESET_VECTOR    32'h0000_0000  PC loaded on reset (bits[1:0] must be 0)
// PC_STEP         4              PC increment per accepted instruction
// TIMEOUT_CYCLES  255            WAIT cycles before re-issue; 0 disables timeout
// PORTS
// clk                  in   1   clock, all state on rising edge
// rst                  in   1   asynchronous, active-high reset
// PCAddressBus         out  32  fetch address to MemoryController
// PCGetNewInstruction  out  1   fetch request strobe, 1 cycle per request
// InstructionBus       in   32  fetched word from MemoryController
// ValidMemoryData      in   1   InstructionBus valid (level, may stay high several cycles)
// InstrOut             out  32  instruction to decode
// InstrPC              out  32  address InstrOut was fetched from
// InstrValid           out  1   InstrOut/InstrPC valid
// InstrReady           in   1   decode accepts InstrOut this cycle
// BranchTaken          in   1   1-cycle redirect pulse from execute
// BranchTarget         in   32  redirect address; bits[1:0] forced to 0
// Halt                 in   1   stop issuing new fetches
// FetchTimeout         out  1   1-cycle pulse when a fetch is re-issued on timeout
// BEHAVIOUR
// - Reset: state IDLE, PC=PCAddressBus=RESET_VECTOR, PCGetNewInstruction=0, InstrValid=0,
//   InstrOut=0, InstrPC=0, FetchTimeout=0, discard=0, timeout counter=0. Reset mid-fetch aborts.
// - FSM IDLE -> REQ -> WAIT -> HOLD -> REQ ...
//   IDLE: Halt=0 -> REQ next cycle.
//   REQ: PCAddressBus=PC, PCGetNewInstruction=1 for exactly this cycle; -> WAIT; clear counter,
//     clear seen_low.
//   WAIT: PCAddressBus held at request address; PCGetNewInstruction=0. Response accepted only
//     when ValidMemoryData=1 AND seen_low=1 (ValidMemoryData sampled 0 at least once since REQ);
//     a level still high from the previous transfer is never re-captured.
//     Accept, discard=0: InstrOut<=InstructionBus, InstrPC<=PC, InstrValid<=1, PC<=PC+PC_STEP,
//     -> HOLD. Accept, discard=1: data dropped, discard<=0, -> REQ (PC already = target).
//     Counter hits TIMEOUT_CYCLES without accept: FetchTimeout=1 one cycle, -> REQ, same PC.
//   HOLD: InstrValid=1, InstrOut/InstrPC stable. InstrReady=1: InstrValid<=0; Halt ? IDLE : REQ.
// - Latency: ValidMemoryData accepted in cycle M -> InstrValid=1 in M+1. Handshake in cycle H ->
//   next PCGetNewInstruction in H+1. Max 1 outstanding fetch.
// - PC arithmetic: 32-bit modulo; 32'hFFFF_FFFC + 4 = 0.
// - BranchTaken (any state): PC <= {BranchTarget[31:2],2'b00}.
//   IDLE: PC update only. REQ or WAIT: in-flight fetch marked discard=1, continue WAIT.
//   HOLD: InstrValid<=0 (flush), InstrReady ignored that cycle, -> REQ.
//   BranchTaken with accept in WAIT (discard=0): data dropped, -> REQ at target.
//   BranchTaken with timeout: -> REQ at target, discard=0, FetchTimeout still pulses.
// - Halt sampled only in IDLE and at HOLD handshake; an outstanding fetch always completes.
// - ValidMemoryData outside WAIT ignored (still updates seen_low only in WAIT).
// TESTING
// 1 Reset release, ValidMemoryData after 5 cycles with InstructionBus=32'h153 -> one-cycle
//   PCGetNewInstruction at PCAddressBus=0; next cycle InstrValid=1, InstrOut=32'h153, InstrPC=0;
//   after InstrReady, next request at PCAddressBus=4.
// 2 InstrReady low 3 cycles in HOLD -> InstrOut/InstrPC/InstrValid stable, no PCGetNewInstruction
//   until cycle after InstrReady=1.
// 3 Fetch of 540 in WAIT, BranchTaken with BranchTarget=32'd4467 -> returned word dropped
//   (InstrValid stays 0), next request PCAddressBus=32'd4464.
// 4 HOLD with BranchTaken=1 and InstrReady=1 same cycle, target 32'h100 -> InstrValid=0 next
//   cycle, next request at 32'h100.
// 5 TIMEOUT_CYCLES=8, no ValidMemoryData -> FetchTimeout pulse after 8 WAIT cycles, re-request
//   same PC; then ValidMemoryData held high 4 cycles -> exactly one capture.
// 6 RESET_VECTOR=32'hFFFF_FFFC, two fetches accepted -> second PCAddressBus=0; rst asserted
//   mid-WAIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one fetch at a time,
// hands instructions to decode over valid/ready and redirects on branches.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter logic [31:0] PC_STEP        = 32'd4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PCAddressBus,
  output logic        PCGetNewInstruction,
  input  logic [31:0] InstructionBus,
  input  logic        ValidMemoryData,
  output logic [31:0] InstrOut,
  output logic [31:0] InstrPC,
  output logic        InstrValid,
  input  logic        InstrReady,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Halt,
  output logic        FetchTimeout
);

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [31:0]   r_pc;
  logic [31:0]   r_addr;
  logic [31:0]   r_out;
  logic [31:0]   r_ipc;
  logic          r_valid;
  logic          r_discard;
  logic          r_seen_low;
  logic [CW-1:0] r_cnt;
  logic          r_to;

  logic [31:0]   w_target;
  logic          w_accept;
  logic          w_timeout;
  logic          w_capture;
  logic          w_clr_valid;
  logic          w_set_discard;
  logic          w_clr_discard;

  assign w_target  = {BranchTarget[31:2], 2'b00};
  // a level left high by the previous transfer never counts as a response
  assign w_accept  = (r_state == S_WAIT) && ValidMemoryData && r_seen_low;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_state == S_WAIT) &&
                     !w_accept && (r_cnt == CNT_LAST);

  assign PCAddressBus        = (r_state == S_REQ) ? r_pc : r_addr;
  assign PCGetNewInstruction = (r_state == S_REQ);
  assign InstrOut            = r_out;
  assign InstrPC             = r_ipc;
  assign InstrValid          = r_valid;
  assign FetchTimeout        = r_to;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // next-state and control decode
  always_comb begin
    w_next        = r_state;
    w_capture     = 1'b0;
    w_clr_valid   = 1'b0;
    w_set_discard = 1'b0;
    w_clr_discard = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!Halt) w_next = S_REQ;
      end
      S_REQ: begin
        w_next = S_WAIT;
        if (BranchTaken) w_set_discard = 1'b1;
      end
      S_WAIT: begin
        if (w_accept) begin
          if (r_discard || BranchTaken) begin
            w_next        = S_REQ;
            w_clr_discard = 1'b1;
          end else begin
            w_capture = 1'b1;
            w_next    = S_HOLD;
          end
        end else if (w_timeout) begin
          w_next        = S_REQ;
          w_clr_discard = 1'b1;
        end else if (BranchTaken) begin
          w_set_discard = 1'b1;
        end
      end
      S_HOLD: begin
        if (BranchTaken) begin
          w_clr_valid = 1'b1;
          w_next      = S_REQ;
        end else if (InstrReady) begin
          w_clr_valid = 1'b1;
          w_next      = Halt ? S_IDLE : S_REQ;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // PC, request address and instruction hold registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc    <= RESET_VECTOR;
      r_addr  <= RESET_VECTOR;
      r_out   <= 32'd0;
      r_ipc   <= 32'd0;
      r_valid <= 1'b0;
    end else begin
      if (BranchTaken)    r_pc <= w_target;
      else if (w_capture) r_pc <= r_pc + PC_STEP;
      if (r_state == S_REQ) r_addr <= r_pc;
      if (w_capture) begin
        r_out   <= InstructionBus;
        r_ipc   <= r_addr;
        r_valid <= 1'b1;
      end else if (w_clr_valid) begin
        r_valid <= 1'b0;
      end
    end
  end

  // wrong-path tracking, response qualification and timeout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_discard  <= 1'b0;
      r_seen_low <= 1'b0;
      r_cnt      <= '0;
      r_to       <= 1'b0;
    end else begin
      if (w_set_discard)      r_discard <= 1'b1;
      else if (w_clr_discard) r_discard <= 1'b0;
      if (r_state == S_REQ) begin
        r_seen_low <= 1'b0;
        r_cnt      <= '0;
      end else if (r_state == S_WAIT) begin
        if (!ValidMemoryData) r_seen_low <= 1'b1;
        if (!w_accept && !w_timeout) r_cnt <= r_cnt + 1'b1;
      end
      r_to <= w_timeout;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: two instances share stimulus,
// one from address 0 with a short timeout, one from the top of memory.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bus = 32'd0;
  logic        vmd = 1'b0;
  logic        rdy = 1'b0;
  logic        br = 1'b0;
  logic [31:0] tgt = 32'd0;
  logic        halt = 1'b0;

  logic [31:0] a_addr, a_out, a_ipc;
  logic        a_req, a_valid, a_to;
  logic [31:0] b_addr, b_out, b_ipc;
  logic        b_req, b_valid, b_to;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .RESET_VECTOR(32'h0000_0000),
    .PC_STEP(32'd4),
    .TIMEOUT_CYCLES(8)
  ) u_a (
    .clk(clk), .rst(rst),
    .PCAddressBus(a_addr), .PCGetNewInstruction(a_req),
    .InstructionBus(bus), .ValidMemoryData(vmd),
    .InstrOut(a_out), .InstrPC(a_ipc), .InstrValid(a_valid),
    .InstrReady(rdy), .BranchTaken(br), .BranchTarget(tgt),
    .Halt(halt), .FetchTimeout(a_to)
  );

  instruction_fetch_unit #(
    .RESET_VECTOR(32'hFFFF_FFFC),
    .PC_STEP(32'd4),
    .TIMEOUT_CYCLES(255)
  ) u_b (
    .clk(clk), .rst(rst),
    .PCAddressBus(b_addr), .PCGetNewInstruction(b_req),
    .InstructionBus(bus), .ValidMemoryData(vmd),
    .InstrOut(b_out), .InstrPC(b_ipc), .InstrValid(b_valid),
    .InstrReady(rdy), .BranchTaken(br), .BranchTarget(tgt),
    .Halt(halt), .FetchTimeout(b_to)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    n_cmp++;
    if ({a_addr, a_req, a_valid, a_out, a_ipc, a_to} !==
        {32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_a: addr=%h req=%b v=%b out=%h pc=%h to=%b want 0",
               a_addr, a_req, a_valid, a_out, a_ipc, a_to);
    end
    n_cmp++;
    if (b_addr !== 32'hFFFF_FFFC) begin
      n_bad++;
      $display("FAIL reset_b_addr: got %h want fffffffc", b_addr);
    end
  endtask

  task automatic test_basic_fetch();
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({a_req, a_addr} !== {1'b1, 32'd0}) begin
      n_bad++;
      $display("FAIL t1_req: req=%b addr=%h want 1/0", a_req, a_addr);
    end
    tick();
    n_cmp++;
    if ({a_req, a_addr, a_valid} !== {1'b0, 32'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL t1_wait: req=%b addr=%h v=%b want 0/0/0",
               a_req, a_addr, a_valid);
    end
    repeat (4) tick();
    vmd = 1'b1;
    bus = 32'h153;
    tick();
    vmd = 1'b0;
    n_cmp++;
    if ({a_valid, a_out, a_ipc, a_req} !== {1'b1, 32'h153, 32'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL t1_capture: v=%b out=%h pc=%h req=%b want 1/153/0/0",
               a_valid, a_out, a_ipc, a_req);
    end
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    n_cmp++;
    if ({a_req, a_addr, a_valid} !== {1'b1, 32'd4, 1'b0}) begin
      n_bad++;
      $display("FAIL t1_next_req: req=%b addr=%h v=%b want 1/4/0",
               a_req, a_addr, a_valid);
    end
    tick();
  endtask

  task automatic test_hold_stall();
    tick();
    vmd = 1'b1;
    bus = 32'hA5A5_0001;
    tick();
    vmd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({a_valid, a_out, a_ipc, a_req} !==
          {1'b1, 32'hA5A5_0001, 32'd4, 1'b0}) begin
        n_bad++;
        $display("FAIL t2_hold%0d: v=%b out=%h pc=%h req=%b want 1/a5a50001/4/0",
                 i, a_valid, a_out, a_ipc, a_req);
      end
      tick();
    end
    n_cmp++;
    if ({a_valid, a_req} !== {1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL t2_hold3: v=%b req=%b want 1/0", a_valid, a_req);
    end
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    n_cmp++;
    if ({a_req, a_addr} !== {1'b1, 32'd8}) begin
      n_bad++;
      $display("FAIL t2_release: req=%b addr=%h want 1/8", a_req, a_addr);
    end
    tick();
  endtask

  task automatic test_branch_wait();
    br = 1'b1;
    tgt = 32'd540;
    tick();
    br = 1'b0;
    tick();
    vmd = 1'b1;
    bus = 32'hDEAD_0008;
    tick();
    vmd = 1'b0;
    n_cmp++;
    if ({a_valid, a_req, a_addr} !== {1'b0, 1'b1, 32'd540}) begin
      n_bad++;
      $display("FAIL t3_redirect540: v=%b req=%b addr=%0d want 0/1/540",
               a_valid, a_req, a_addr);
    end
    tick();
    br = 1'b1;
    tgt = 32'd4467;
    tick();
    br = 1'b0;
    n_cmp++;
    if ({a_req, a_addr} !== {1'b0, 32'd540}) begin
      n_bad++;
      $display("FAIL t3_addr_held: req=%b addr=%0d want 0/540", a_req, a_addr);
    end
    tick();
    vmd = 1'b1;
    bus = 32'hBAD0_021C;
    tick();
    vmd = 1'b0;
    n_cmp++;
    if ({a_valid, a_req, a_addr} !== {1'b0, 1'b1, 32'd4464}) begin
      n_bad++;
      $display("FAIL t3_dropped: v=%b req=%b addr=%0d want 0/1/4464",
               a_valid, a_req, a_addr);
    end
    tick();
    tick();
    vmd = 1'b1;
    bus = 32'h0000_1170;
    tick();
    vmd = 1'b0;
    n_cmp++;
    if ({a_valid, a_out, a_ipc} !== {1'b1, 32'h1170, 32'd4464}) begin
      n_bad++;
      $display("FAIL t3_target_fetch: v=%b out=%h pc=%0d want 1/1170/4464",
               a_valid, a_out, a_ipc);
    end
  endtask

  task automatic test_branch_hold();
    br = 1'b1;
    rdy = 1'b1;
    tgt = 32'h100;
    tick();
    br = 1'b0;
    rdy = 1'b0;
    n_cmp++;
    if ({a_valid, a_req, a_addr} !== {1'b0, 1'b1, 32'h100}) begin
      n_bad++;
      $display("FAIL t4_flush: v=%b req=%b addr=%h want 0/1/100",
               a_valid, a_req, a_addr);
    end
    tick();
    tick();
    vmd = 1'b1;
    bus = 32'h0000_0100;
    tick();
    vmd = 1'b0;
    n_cmp++;
    if ({a_valid, a_ipc} !== {1'b1, 32'h100}) begin
      n_bad++;
      $display("FAIL t4_fetch: v=%b pc=%h want 1/100", a_valid, a_ipc);
    end
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    n_cmp++;
    if ({a_req, a_addr} !== {1'b1, 32'h104}) begin
      n_bad++;
      $display("FAIL t4_next: req=%b addr=%h want 1/104", a_req, a_addr);
    end
    tick();
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 7; i++) begin
      tick();
      n_cmp++;
      if ({a_to, a_req} !== 2'b00) begin
        n_bad++;
        $display("FAIL t5_early%0d: to=%b req=%b want 0/0", i, a_to, a_req);
      end
    end
    tick();
    n_cmp++;
    if ({a_to, a_req, a_addr} !== {1'b1, 1'b1, 32'h104}) begin
      n_bad++;
      $display("FAIL t5_timeout: to=%b req=%b addr=%h want 1/1/104",
               a_to, a_req, a_addr);
    end
    tick();
    n_cmp++;
    if ({a_to, a_req} !== 2'b00) begin
      n_bad++;
      $display("FAIL t5_pulse_end: to=%b req=%b want 0/0", a_to, a_req);
    end
    tick();
    vmd = 1'b1;
    bus = 32'h0000_5555;
    rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (a_valid !== (i == 0)) begin
        n_bad++;
        $display("FAIL t5_capture%0d: v=%b want %0d", i, a_valid, (i == 0));
      end
    end
    vmd = 1'b0;
    rdy = 1'b0;
    n_cmp++;
    if ({a_out, a_ipc, a_addr} !== {32'h5555, 32'h104, 32'h108}) begin
      n_bad++;
      $display("FAIL t5_once: out=%h pc=%h addr=%h want 5555/104/108",
               a_out, a_ipc, a_addr);
    end
  endtask

  task automatic test_wrap_and_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if ({b_req, b_addr} !== {1'b1, 32'hFFFF_FFFC}) begin
      n_bad++;
      $display("FAIL t6_first: req=%b addr=%h want 1/fffffffc", b_req, b_addr);
    end
    tick();
    tick();
    vmd = 1'b1;
    bus = 32'h0000_0FFC;
    tick();
    vmd = 1'b0;
    n_cmp++;
    if ({b_valid, b_ipc} !== {1'b1, 32'hFFFF_FFFC}) begin
      n_bad++;
      $display("FAIL t6_capture: v=%b pc=%h want 1/fffffffc", b_valid, b_ipc);
    end
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    n_cmp++;
    if ({b_req, b_addr} !== {1'b1, 32'd0}) begin
      n_bad++;
      $display("FAIL t6_wrap: req=%b addr=%h want 1/0", b_req, b_addr);
    end
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({b_addr, b_req, b_valid, b_out, b_ipc, b_to} !==
        {32'hFFFF_FFFC, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL t6_async_rst: addr=%h req=%b v=%b out=%h pc=%h to=%b",
               b_addr, b_req, b_valid, b_out, b_ipc, b_to);
    end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_hold_stall();
    test_branch_wait();
    test_branch_hold();
    test_timeout();
    test_wrap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
